bit_sampler: RTL

BIT_SAMPLER -- requirements
Module: bit_sampler

---
 rtl/bit_sampler.sv | 81 ++++++++
 1 files changed

// File: rtl/bit_sampler.sv
// Debounced push-button sampler: latches one serial bit from sw_in per accepted key press.
// Strobe DEB_CYCLES+2 edges after a clean press. No backpressure. Macro BIT_SAMPLER_HIST_EN adds a 4-bit history.
module bit_sampler #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic       sw_in,
  output logic       bit_valid,
  output logic       bit_data,
  output logic [3:0] hist,
  output logic [3:0] bit_count
);

  localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 1);

  logic        key_s1;
  logic        key_s;
  logic        sw_s1;
  logic        sw_s;
  logic        key_db;
  logic [19:0] deb_cnt;
  logic        mismatch;
  logic        accept;
  logic        press;

  assign mismatch = (key_s != key_db);
  assign accept   = mismatch && (deb_cnt == DEB_LAST);
  // Only the high-to-low transition of the debounced level counts as a bit.
  assign press    = accept && key_db;

  always_ff @(posedge clock) begin
    if (!reset) begin
      key_s1    <= 1'b1;
      key_s     <= 1'b1;
      sw_s1     <= 1'b0;
      sw_s      <= 1'b0;
      key_db    <= 1'b1;
      deb_cnt   <= 20'd0;
      bit_valid <= 1'b0;
      bit_data  <= 1'b0;
      bit_count <= 4'h0;
    end else begin
      key_s1    <= key_n;
      key_s     <= key_s1;
      sw_s1     <= sw_in;
      sw_s      <= sw_s1;
      bit_valid <= press;
      if (!mismatch) begin
        deb_cnt <= 20'd0;
      end else if (accept) begin
        key_db  <= key_s;
        deb_cnt <= 20'd0;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
      if (press) begin
        bit_data <= sw_s;
        if (bit_count != 4'hf) bit_count <= bit_count + 4'h1;
      end
    end
  end

`ifdef BIT_SAMPLER_HIST_EN
  logic [3:0] hist_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hist_q <= 4'h0;
    end else if (press) begin
      hist_q <= {hist_q[2:0], sw_s};
    end
  end

  assign hist = hist_q;
`else
  assign hist = 4'h0;
`endif

endmodule
